// File: rtl/str_decim.sv
// str_decim: AXI-Stream decimate-by-R, pick or boxcar-average mode,
// with a 2-entry output buffer (main + skid).
module str_decim #(
  parameter int DW  = 12,
  parameter int R   = 4,
  parameter bit AVG = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync_clr,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready
);

  localparam int LOG2R = $clog2(R);
  localparam int PW    = (LOG2R > 0) ? LOG2R : 1;
  localparam int AW    = DW + LOG2R;
  localparam logic [PW-1:0] PH_LAST = PW'(R - 1);

  logic [PW-1:0]        ph;
  logic [PW-1:0]        ph_cur;
  logic [PW-1:0]        ph_nxt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_cur;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW-1:0] sum;
  logic signed [DW-1:0] smp;
  logic [DW-1:0]        res;
  logic [DW-1:0]        main_q;
  logic [DW-1:0]        skid_q;
  logic                 main_vld;
  logic                 skid_vld;
  logic                 ish;
  logic                 osh;
  logic                 last;
  logic                 res_vld;

  // sync_clr acts as if phase and accumulator were already zero
  always_comb begin
    ish     = s_axis_tvalid & ~skid_vld;
    osh     = main_vld & m_axis_tready;
    smp     = s_axis_tdata;
    ph_cur  = sync_clr ? '0 : ph;
    acc_cur = sync_clr ? '0 : acc;
    last    = (ph_cur == PH_LAST);
    sum     = acc_cur + AW'(smp);
    ph_nxt  = ph_cur;
    acc_nxt = acc_cur;
    res_vld = 1'b0;
    res     = s_axis_tdata;
    if (ish) begin
      ph_nxt = last ? '0 : ph_cur + PW'(1);
      if (AVG) begin
        acc_nxt = last ? '0 : sum;
        res_vld = last;
        res     = DW'(sum >>> LOG2R);
      end else begin
        res_vld = (ph_cur == '0);
      end
    end
  end

  // a result can only appear while skid is empty, so skid never overflows
  always_ff @(posedge clk) begin
    if (rst) begin
      ph       <= '0;
      acc      <= '0;
      main_q   <= '0;
      main_vld <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
    end else begin
      ph  <= ph_nxt;
      acc <= acc_nxt;
      if (res_vld) begin
        if (!main_vld || osh) begin
          main_q   <= res;
          main_vld <= 1'b1;
        end else begin
          skid_q   <= res;
          skid_vld <= 1'b1;
        end
      end else if (osh) begin
        if (skid_vld) begin
          main_q   <= skid_q;
          skid_vld <= 1'b0;
        end else begin
          main_vld <= 1'b0;
        end
      end
    end
  end

  assign s_axis_tready = ~skid_vld;
  assign m_axis_tdata  = main_q;
  assign m_axis_tvalid = main_vld;

endmodule

// File: tb/tb_str_decim.sv
// tb_str_decim: three str_decim instances (R4 avg, R4 pick, R1 pick)
// checked every cycle against a frame/queue model.
module tb_str_decim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[3];
  logic        sc[3];
  logic        tv[3];
  logic        mr[3];
  logic        sr[3];
  logic        mv[3];
  logic [11:0] td[3];
  logic [11:0] md[3];

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // model: output buffer as a 2-deep list, frame as count + running sum
  int obn[3]  = '{0, 0, 0};
  int ob[3][2];
  int fcnt[3] = '{0, 0, 0};
  int fsum[3] = '{0, 0, 0};
  bit acc_ev[3];
  int got[3][$];

  str_decim #(.DW(12), .R(4), .AVG(1'b1)) u_avg (
    .clk(clk), .rst(rst[0]), .sync_clr(sc[0]),
    .s_axis_tdata(td[0]), .s_axis_tvalid(tv[0]),
    .s_axis_tready(sr[0]), .m_axis_tdata(md[0]),
    .m_axis_tvalid(mv[0]), .m_axis_tready(mr[0])
  );

  str_decim #(.DW(12), .R(4), .AVG(1'b0)) u_pick (
    .clk(clk), .rst(rst[1]), .sync_clr(sc[1]),
    .s_axis_tdata(td[1]), .s_axis_tvalid(tv[1]),
    .s_axis_tready(sr[1]), .m_axis_tdata(md[1]),
    .m_axis_tvalid(mv[1]), .m_axis_tready(mr[1])
  );

  str_decim #(.DW(12), .R(1), .AVG(1'b0)) u_r1 (
    .clk(clk), .rst(rst[2]), .sync_clr(sc[2]),
    .s_axis_tdata(td[2]), .s_axis_tvalid(tv[2]),
    .s_axis_tready(sr[2]), .m_axis_tdata(md[2]),
    .m_axis_tvalid(mv[2]), .m_axis_tready(mr[2])
  );

  function automatic int rp(input int c);
    return (c == 2) ? 1 : 4;
  endfunction

  function automatic bit avgp(input int c);
    return (c == 0);
  endfunction

  function automatic int fdiv(input int s, input int r);
    int q;
    q = s / r;
    if ((s % r) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string nm, input int c,
                     input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s ch%0d: got %0d expected %0d at %0t",
               nm, c, act, exp, $time);
    end
  endtask

  task automatic push_res(input int c, input int v);
    ob[c][obn[c]] = v;
    obn[c]++;
  endtask

  task automatic model_step(input int c);
    bit ish;
    bit osh;
    int x;
    if (rst[c]) begin
      obn[c] = 0;
      fcnt[c] = 0;
      fsum[c] = 0;
      acc_ev[c] = 1'b0;
      return;
    end
    ish = (tv[c] === 1'b1) && obn[c] < 2;
    osh = (mr[c] === 1'b1) && obn[c] > 0;
    acc_ev[c] = ish;
    if (osh) begin
      ob[c][0] = ob[c][1];
      obn[c]--;
    end
    if (sc[c]) begin
      fcnt[c] = 0;
      fsum[c] = 0;
    end
    if (ish) begin
      x = int'($signed(td[c]));
      fcnt[c]++;
      fsum[c] += x;
      if (avgp(c)) begin
        if (fcnt[c] == rp(c)) begin
          push_res(c, fdiv(fsum[c], rp(c)));
          fcnt[c] = 0;
          fsum[c] = 0;
        end
      end else begin
        if (fcnt[c] == 1) push_res(c, x);
        if (fcnt[c] == rp(c)) begin
          fcnt[c] = 0;
          fsum[c] = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int c = 0; c < 3; c++) model_step(c);
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int c = 0; c < 3; c++) begin
        chk("s_tready", c, sr[c], int'(obn[c] < 2));
        chk("m_tvalid", c, mv[c], int'(obn[c] > 0));
        if (obn[c] > 0) chk("m_tdata", c, $signed(md[c]), ob[c][0]);
        if (mv[c] === 1'b1 && mr[c] === 1'b1)
          got[c].push_back(int'($signed(md[c])));
      end
    end
  end

  task automatic run(input int c, input int v[$], input int sc_at,
                     input int pv, input int pr, input int hold,
                     input bit drain);
    int idx = 0;
    int cyc = 0;
    bit pres = 1'b0;
    bit newp;
    while (1) begin
      if (pres && acc_ev[c]) begin
        idx++;
        pres = 1'b0;
      end
      if (idx >= v.size() && !(drain && obn[c] != 0)) break;
      if (cyc >= 20000) begin
        checks++;
        errs++;
        $display("FAIL run_timeout ch%0d: sent %0d of %0d, pending %0d",
                 c, idx, v.size(), obn[c]);
        break;
      end
      newp = 1'b0;
      if (!pres && idx < v.size() && $urandom_range(99) < pv) begin
        pres = 1'b1;
        newp = 1'b1;
      end
      tv[c] = pres;
      if (pres) td[c] = 12'(v[idx]);
      sc[c] = newp && (idx == sc_at);
      mr[c] = (cyc >= hold) && ($urandom_range(99) < pr);
      @(posedge clk);
      #1;
      cyc++;
    end
    tv[c] = 1'b0;
    sc[c] = 1'b0;
  endtask

  task automatic expect_out(input string nm, input int c,
                            input int b, input int e[$]);
    chk({nm, "_count"}, c, got[c].size() - b, e.size());
    if (got[c].size() - b == e.size())
      for (int i = 0; i < e.size(); i++)
        chk({nm, "_val"}, c, got[c][b + i], e[i]);
  endtask

  task automatic pulse_rst(input int c, input string nm);
    rst[c] = 1'b1;
    @(posedge clk);
    #1;
    rst[c] = 1'b0;
    @(negedge clk);
    chk({nm, "_tvalid"}, c, mv[c], 0);
    chk({nm, "_tready"}, c, sr[c], 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v[$];
    int e[$];
    int b;
    for (int c = 0; c < 3; c++) begin
      rst[c] = 1'b1;
      sc[c]  = 1'b0;
      tv[c]  = 1'b0;
      mr[c]  = 1'b1;
      td[c]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk("rst_tvalid", c, mv[c], 0);
      chk("rst_tready", c, sr[c], 1);
      chk("rst_tdata", c, $signed(md[c]), 0);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) rst[c] = 1'b0;

    // pick mode, R=4
    b = got[1].size();
    v = {};
    for (int i = 0; i < 12; i++) v.push_back(i);
    run(1, v, -1, 100, 100, 0, 1'b1);
    e = '{0, 4, 8};
    expect_out("t1", 1, b, e);

    // averaging incl. floor of negatives and full-scale frames
    b = got[0].size();
    v = '{100, 200, 300, 400, -1, -2, -3, -4};
    repeat (4) v.push_back(2047);
    repeat (4) v.push_back(-2048);
    run(0, v, -1, 100, 100, 0, 1'b1);
    e = '{250, -3, 2047, -2048};
    expect_out("t2", 0, b, e);

    // R=1 with downstream stalled, then released
    b = got[2].size();
    v = {};
    for (int i = 1; i <= 10; i++) v.push_back(i);
    fork
      run(2, v, -1, 100, 100, 6, 1'b1);
      begin
        repeat (4) @(negedge clk);
        chk("t3_stall_tready", 2, sr[2], 0);
        chk("t3_stall_main", 2, $signed(md[2]), 1);
      end
    join
    e = v;
    expect_out("t3", 2, b, e);

    // sync_clr together with an accept restarts the frame
    b = got[0].size();
    v = '{10, 20, 40, 40, 40, 40};
    run(0, v, 2, 100, 100, 0, 1'b1);
    e = '{40};
    expect_out("t4", 0, b, e);

    // random handshakes on both sides
    b = got[0].size();
    v = {};
    for (int i = 0; i < 1000; i++)
      v.push_back(int'($urandom_range(4095)) - 2048);
    run(0, v, -1, 50, 50, 0, 1'b1);
    chk("t5_count", 0, got[0].size() - b, 250);

    // reset with main+skid full, then with main full mid-frame
    v = '{1, 2, 3, 4, 5, 6, 7, 8};
    run(0, v, -1, 100, 100, 1 << 30, 1'b0);
    pulse_rst(0, "t6a");
    v = '{11, 12, 13, 14, 15, 16};
    run(0, v, -1, 100, 100, 1 << 30, 1'b0);
    pulse_rst(0, "t6b");
    b = got[0].size();
    v = '{-5, -6, -7, -9};
    run(0, v, -1, 100, 100, 0, 1'b1);
    e = '{-7};
    expect_out("t6", 0, b, e);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
